// File: rtl/gpio_pattern_gen.sv
// gpio_pattern_gen
//   Bring-up / self-test stimulus generator for the GPIO_Board display/IO block.
//   One pattern register (pat) and a 0..6 phase counter advance together on every
//   tick. A tick comes from the prescaler while running, or from a rising edge
//   of step while paused. All outputs are pure decode of registered state.
//
// Ports
//   clock       in   board clock, all state on rising edge
//   reset_n     in   asynchronous active-low reset
//   mode        in   2  pattern mode: 0 count, 1 walking one, 2 checkerboard, 3 LFSR
//   run         in   1 = free-run on prescaler, 0 = paused
//   step        in   rising edge gives one tick while paused
//   regs        out  NUM_REGS channels, channel i at [i*REG_WIDTH +: REG_WIDTH]
//   hex_seg     out  NUM_DIGITS 7-seg digits, digit d at [d*7 +: 7], active high
//   hex_dp      out  decimal points, active high
//   tick_out    out  one-cycle pulse, high in the cycle pat shows its new value
//   tick_count  out  ticks since reset, wraps

module gpio_pattern_gen #(
   parameter int                   REG_WIDTH  = 16,
   parameter int                   NUM_REGS   = 8,
   parameter int                   NUM_DIGITS = 8,
   parameter int                   PRESCALE   = 2**24,
   parameter int                   PRESC_W    = 25,
   parameter logic [REG_WIDTH-1:0] LFSR_TAPS  = 16'hB400,
   parameter int                   TICK_W     = 32
) (
   input  logic                            clock,
   input  logic                            reset_n,
   input  logic [1:0]                      mode,
   input  logic                            run,
   input  logic                            step,
   output logic [NUM_REGS*REG_WIDTH-1:0]   regs,
   output logic [NUM_DIGITS*7-1:0]         hex_seg,
   output logic [NUM_DIGITS-1:0]           hex_dp,
   output logic                            tick_out,
   output logic [TICK_W-1:0]               tick_count
);

   // Checkerboard base pattern: 01 repeated across the register.
   localparam logic [REG_WIDTH-1:0] PAT_A      = {(REG_WIDTH/2){2'b01}};
   localparam logic [REG_WIDTH-1:0] PAT_ONE    = REG_WIDTH'(1);
   localparam logic [PRESC_W-1:0]   PRESC_LAST = PRESC_W'(PRESCALE - 1);

   logic [REG_WIDTH-1:0] pat;
   logic [REG_WIDTH-1:0] pat_next;
   logic [PRESC_W-1:0]   presc;
   logic [2:0]           phase;
   logic                 step_q;
   logic                 run_tick;
   logic                 step_tick;
   logic                 tick;
   logic                 pat_onehot;

   assign run_tick  = run & (presc == PRESC_LAST);
   // step is only honoured while paused so a running engine never gets extra ticks.
   assign step_tick = ~run & step & ~step_q;
   assign tick      = run_tick | step_tick;

   assign pat_onehot = (pat != '0) && ((pat & (pat - PAT_ONE)) == '0);

   always_comb begin
      pat_next = pat;
      case (mode)
         2'd0: pat_next = pat + PAT_ONE;
         2'd1: begin
            if (pat_onehot)
               pat_next = {pat[REG_WIDTH-2:0], pat[REG_WIDTH-1]};
            else
               pat_next = PAT_ONE;
         end
         2'd2: pat_next = (pat == PAT_A) ? ~PAT_A : PAT_A;
         default: begin
            // Zero is the LFSR lock-up state; reseed instead of stepping.
            if (pat == '0)
               pat_next = PAT_ONE;
            else
               pat_next = (pat >> 1) ^ (pat[0] ? LFSR_TAPS : '0);
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pat        <= PAT_ONE;
         presc      <= '0;
         phase      <= '0;
         step_q     <= 1'b0;
         tick_out   <= 1'b0;
         tick_count <= '0;
      end else begin
         step_q   <= step;
         tick_out <= tick;
         if (run)
            presc <= (presc == PRESC_LAST) ? '0 : presc + PRESC_W'(1);
         if (tick) begin
            pat        <= pat_next;
            phase      <= (phase == 3'd6) ? 3'd0 : phase + 3'd1;
            tick_count <= tick_count + TICK_W'(1);
         end
      end
   end

   // Channel i is pat rotated left by (i mod REG_WIDTH), odd channels inverted.
   for (genvar i = 0; i < NUM_REGS; i++) begin : g_ch
      localparam int K = i % REG_WIDTH;
      logic [REG_WIDTH-1:0] rot;
      if (K == 0) begin : g_norot
         assign rot = pat;
      end else begin : g_rot
         assign rot = {pat[REG_WIDTH-1-K:0], pat[REG_WIDTH-1:REG_WIDTH-K]};
      end
      if ((i % 2) == 1) begin : g_inv
         assign regs[i*REG_WIDTH +: REG_WIDTH] = ~rot;
      end else begin : g_pass
         assign regs[i*REG_WIDTH +: REG_WIDTH] = rot;
      end
   end

   // Digit d lights the single segment (phase + d) mod 7, so the lit segment
   // chases around the display as phase advances.
   for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dig
      localparam logic [3:0] DOFF = 4'(d % 7);
      localparam logic       DPAR = 1'(d % 2);
      logic [3:0] seg_sum;
      logic [3:0] seg_idx;
      assign seg_sum = {1'b0, phase} + DOFF;
      assign seg_idx = (seg_sum >= 4'd7) ? seg_sum - 4'd7 : seg_sum;
      assign hex_seg[d*7 +: 7] = 7'b0000001 << seg_idx;
      assign hex_dp[d]         = phase[0] ^ DPAR;
   end

endmodule
